// File: rtl/fp_decoder_if.sv
// Handshake and data bundle for the fp_decoder: a {s,e,f} float word
// goes in, a 12-bit two's-complement linear value comes out.
interface fp_decoder_if;
  logic        in_valid;
  logic        in_ready;
  logic        s;
  logic [2:0]  e;
  logic [3:0]  f;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] d;
  logic        busy;

  // Producer/consumer side: drives the input word and accepts results
  modport master (
    output in_valid, s, e, f, out_ready,
    input  in_ready, out_valid, d, busy
  );

  // Decoder side
  modport slave (
    input  in_valid, s, e, f, out_ready,
    output in_ready, out_valid, d, busy
  );
endinterface

// File: rtl/fp_decoder.sv
// fp_decoder: converts a small float {s,e,f} into d = (s ? -1 : +1) * (f << e)
// using a serial shifter (one shift per clock), then holds the result until
// the consumer takes it. One operation in flight at a time.
module fp_decoder (
  input  logic         clk,
  input  logic         rst_n,
  fp_decoder_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [11:0] acc_q, acc_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        sign_q, sign_d;
  logic [11:0] d_q, d_d;
  logic        out_valid_q, out_valid_d;

  // Next-state logic: accept in IDLE, shift down the exponent count, finalise, then hold
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    sign_d      = sign_q;
    d_d         = d_q;
    out_valid_d = out_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          sign_d  = bus.s;
          cnt_d   = bus.e;
          acc_d   = {8'b0000_0000, bus.f};
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (cnt_q != 3'd0) begin
          acc_d = {acc_q[10:0], 1'b0};
          cnt_d = cnt_q - 3'd1;
        end else begin
          // Negating zero wraps back to zero, so f=0 never yields a negative zero
          d_d         = sign_q ? (~acc_q + 12'd1) : acc_q;
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        // The handshake edge only returns to IDLE; a new word is taken no earlier than the next edge
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          state_d     = ST_DONE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State registers; asynchronous reset discards any in-flight operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      acc_q       <= 12'd0;
      cnt_q       <= 3'd0;
      sign_q      <= 1'b0;
      d_q         <= 12'd0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      sign_q      <= sign_d;
      d_q         <= d_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Status outputs decode registered state only, so no input reaches them combinationally
  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.d         = d_q;

endmodule

// File: tb/tb_fp_decoder.sv
// Directed bench for fp_decoder: vector table, backpressure, reset mid-op,
// and a full sweep of all 256 input words with randomised out_ready.
module tb_fp_decoder;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  fp_decoder_if bus ();

  fp_decoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        s;
    logic [2:0]  e;
    logic [3:0]  f;
    logic [11:0] exp_d;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one word for exactly one edge
  task automatic start_op(input logic si, input logic [2:0] ei, input logic [3:0] fi);
    bus.s        = si;
    bus.e        = ei;
    bus.f        = fi;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Counts edges inclusive of the accepting edge until out_valid is seen (bounded)
  task automatic wait_valid(output int lat);
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 30) begin
      tick();
      lat++;
    end
  endtask

  function automatic logic [11:0] model_dec(input logic si, input logic [2:0] ei, input logic [3:0] fi);
    logic [11:0] mag;
    mag = {8'h00, fi} << ei;
    return si ? (12'd0 - mag) : mag;
  endfunction

  // Linear-to-float encoder: keep the top four significant bits
  function automatic logic [7:0] model_enc(input logic [11:0] dv);
    logic [11:0] mag;
    int          msb;
    int          ee;
    logic [11:0] ff;
    mag = dv[11] ? (12'd0 - dv) : dv;
    msb = 0;
    for (int b = 0; b < 12; b++) begin
      if (mag[b]) msb = b;
    end
    ee = (msb > 3) ? msb - 3 : 0;
    ff = mag >> ee;
    return {dv[11], ee[2:0], ff[3:0]};
  endfunction

  initial begin
    int          lat;
    logic [7:0]  enc;
    logic [11:0] exp_d;
    logic        rdy;
    int          waits;

    n_checks = 0;
    n_fail   = 0;

    vecs[0] = '{1'b0, 3'd7, 4'd15, 12'h780};
    vecs[1] = '{1'b1, 3'd7, 4'd15, 12'h880};
    vecs[2] = '{1'b1, 3'd0, 4'd1,  12'hFFF};
    vecs[3] = '{1'b1, 3'd5, 4'd0,  12'h000};
    vecs[4] = '{1'b0, 3'd3, 4'd9,  12'h048};
    vecs[5] = '{1'b0, 3'd0, 4'd0,  12'h000};
    vecs[6] = '{1'b1, 3'd3, 4'd5,  12'hFD8};
    vecs[7] = '{1'b0, 3'd4, 4'd1,  12'h010};
    vecs[8] = '{1'b1, 3'd7, 4'd1,  12'hF80};
    vecs[9] = '{1'b0, 3'd2, 4'd13, 12'h034};

    bus.in_valid  = 1'b0;
    bus.s         = 1'b0;
    bus.e         = 3'd0;
    bus.f         = 4'd0;
    bus.out_ready = 1'b1;
    rst_n         = 1'b0;
    tick();
    tick();
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_d",         {20'd0, bus.d},         32'd0);
    check("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    check("rst_busy",      {31'd0, bus.busy},      32'd0);
    rst_n = 1'b1;
    tick();

    // Table-driven vectors with out_ready held high
    for (int i = 0; i < 10; i++) begin
      start_op(vecs[i].s, vecs[i].e, vecs[i].f);
      check("vec_busy_after_accept", {31'd0, bus.busy}, 32'd1);
      check("vec_in_ready_shift", {31'd0, bus.in_ready}, 32'd0);
      wait_valid(lat);
      check($sformatf("vec%0d_latency", i), lat, {29'd0, vecs[i].e} + 32'd2);
      check($sformatf("vec%0d_d", i), {20'd0, bus.d}, {20'd0, vecs[i].exp_d});
      tick();
      check("vec_out_valid_cleared", {31'd0, bus.out_valid}, 32'd0);
      check("vec_idle_in_ready", {31'd0, bus.in_ready}, 32'd1);
      check("vec_d_retained", {20'd0, bus.d}, {20'd0, vecs[i].exp_d});
    end

    // Backpressure: result held, new input ignored, no accept on the handshake edge
    bus.out_ready = 1'b0;
    start_op(1'b0, 3'd3, 4'd9);
    wait_valid(lat);
    check("bp_latency", lat, 32'd5);
    bus.s = 1'b1; bus.e = 3'd1; bus.f = 4'd7; bus.in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("bp_d_held", {20'd0, bus.d}, 32'h048);
      check("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
      check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
    end
    bus.out_ready = 1'b1;
    tick();
    check("bp_release_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("bp_no_accept_on_handshake", {31'd0, bus.busy}, 32'd0);
    tick();
    check("bp_accept_next_edge", {31'd0, bus.busy}, 32'd1);
    bus.in_valid = 1'b0;
    wait_valid(lat);
    check("bp_second_latency", lat, 32'd3);
    check("bp_second_d", {20'd0, bus.d}, 32'hFF2);
    tick();

    // Reset mid-SHIFT: immediate effect, no stale result afterward
    start_op(1'b0, 3'd6, 4'd3);
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_mid_d", {20'd0, bus.d}, 32'd0);
    check("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_mid_in_ready", {31'd0, bus.in_ready}, 32'd1);
    tick();
    tick();
    rst_n = 1'b1;
    start_op(1'b0, 3'd1, 4'd2);
    check("rst_first_edge_accept", {31'd0, bus.busy}, 32'd1);
    wait_valid(lat);
    check("rst_new_latency", lat, 32'd3);
    check("rst_new_d", {20'd0, bus.d}, 32'h004);
    tick();

    // Exhaustive sweep with random backpressure and round-trip re-encode
    for (int i = 0; i < 256; i++) begin
      logic [7:0] w;
      w = i[7:0];
      exp_d = model_dec(w[7], w[6:4], w[3:0]);
      bus.out_ready = 1'b0;
      start_op(w[7], w[6:4], w[3:0]);
      wait_valid(lat);
      check("sweep_latency", lat, {29'd0, w[6:4]} + 32'd2);
      check($sformatf("sweep_d_%02h", w), {20'd0, bus.d}, {20'd0, exp_d});
      enc = model_enc(bus.d);
      check("sweep_roundtrip", {20'd0, model_dec(enc[7], enc[6:4], enc[3:0])}, {20'd0, exp_d});
      waits = 0;
      rdy = 1'b0;
      while (!rdy) begin
        rdy = (waits >= 6) ? 1'b1 : 1'($urandom_range(0, 1));
        bus.out_ready = rdy;
        tick();
        waits++;
        if (!rdy) begin
          check("sweep_hold_d", {20'd0, bus.d}, {20'd0, exp_d});
        end else begin
          check("sweep_release", {31'd0, bus.out_valid}, 32'd0);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
